// File: rtl/arbitro_somador_pkg.sv
// Shared constants for the round-robin adder arbiter: FSM encodings and the
// width of the completed-operation counter.
package arbitro_somador_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int OPS_W = 8;

endpackage

// File: rtl/arbitro_somador_somador.sv
// Shared combinational adder; the carry out is discarded so the sum wraps.
module somador #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] soma
);

    assign soma = a + b;

endmodule

// File: rtl/arbitro_somador.sv
// Round-robin arbiter that time-shares one somador between NREQ requesters
// and returns each sum, tagged with the owner id, on one response channel.
module arbitro_somador
    import arbitro_somador_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_soma,
    output logic [OPS_W-1:0]      ops_count
);

    logic [1:0]       state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   op_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] soma;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic             grant_found;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        if (int'(id) >= NREQ - 1)
            return '0;
        return id + 1'b1;
    endfunction

    // Scan from the far end back to rr_ptr so the closest valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && grant_found)
            req_ready[grant_idx] = 1'b1;
    end

    somador #(
        .WIDTH(WIDTH)
    ) u_somador (
        .a   (op_a),
        .b   (op_b),
        .soma(soma)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_soma  <= '0;
            ops_count  <= '0;
        end else begin
            case (state)
                // accept: capture the granted requester's operands
                IDLE: begin
                    if (grant_found) begin
                        op_a  <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
                        op_b  <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
                        op_id <= grant_idx;
                        state <= CALC;
                    end
                end
                // adder settles on op_a/op_b; register its result
                CALC: begin
                    resp_soma  <= soma;
                    resp_id    <= op_id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                // hold the response until the consumer takes it
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        ops_count  <= ops_count + 1'b1;
                        rr_ptr     <= next_id(op_id);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_somador.sv
// Scoreboard bench for arbitro_somador: per-requester operation queues, a
// round-robin reference model and a decoupled response monitor.
`timescale 1ns/1ps
module tb_arbitro_somador;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] soma;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready = 1'b1;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_soma;
    logic [7:0]            ops_count;

    int   vectors     = 0;
    int   miscompares = 0;
    int   model_ptr   = 0;
    int   model_cnt   = 0;
    int   bp_mode     = 0;
    op_t  stimq[NREQ][$];
    op_t  stage[NREQ][$];
    exp_t expq[$];

    arbitro_somador #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_soma (resp_soma),
        .ops_count (ops_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int pending_stim();
        int n;
        n = 0;
        for (int i = 0; i < NREQ; i++) n += stimq[i].size();
        return n;
    endfunction

    task automatic add_op(input int id, input int a, input int b);
        op_t o;
        o.a = WIDTH'(a);
        o.b = WIDTH'(b);
        stage[id].push_back(o);
    endtask

    // Reference model: serve staged ops in round-robin order from model_ptr.
    task automatic commit();
        int   ptr;
        int   idx;
        bit   any;
        op_t  o;
        exp_t e;
        ptr = model_ptr;
        forever begin
            any = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (ptr + k) % NREQ;
                if (stage[idx].size() > 0) begin
                    o      = stage[idx].pop_front();
                    e.id   = IDW'(idx);
                    e.soma = WIDTH'((int'(o.a) + int'(o.b)) % (1 << WIDTH));
                    expq.push_back(e);
                    stimq[idx].push_back(o);
                    ptr = (idx + 1) % NREQ;
                    any = 1'b1;
                    break;
                end
            end
            if (!any) break;
        end
        model_ptr = ptr;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((expq.size() != 0 || pending_stim() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0 || pending_stim() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", expq.size());
            expq.delete();
            for (int i = 0; i < NREQ; i++) stimq[i].delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        expq.delete();
        for (int i = 0; i < NREQ; i++) begin
            stimq[i].delete();
            stage[i].delete();
        end
        model_ptr = 0;
        @(posedge clk);
        #1;
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_resp_id", int'(resp_id), 0);
        check("rst_resp_soma", int'(resp_soma), 0);
        check("rst_ops_count", int'(ops_count), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Requester drivers: present the head of each queue, pop on acceptance.
    initial begin : driver
        logic [NREQ-1:0] acc;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(negedge clk);
            #1;
            acc = req_ready & req_valid;
            @(posedge clk);
            #1;
            if (!rst)
                for (int i = 0; i < NREQ; i++)
                    if (acc[i] && stimq[i].size() > 0) void'(stimq[i].pop_front());
            for (int i = 0; i < NREQ; i++) begin
                if (stimq[i].size() > 0) begin
                    req_valid[i]               = 1'b1;
                    req_a[i*WIDTH +: WIDTH]    = stimq[i][0].a;
                    req_b[i*WIDTH +: WIDTH]    = stimq[i][0].b;
                end else begin
                    req_valid[i]               = 1'b0;
                    req_a[i*WIDTH +: WIDTH]    = WIDTH'($urandom);
                    req_b[i*WIDTH +: WIDTH]    = WIDTH'($urandom);
                end
            end
        end
    end

    initial begin : consumer
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = 1'b0;
                default: resp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        bit             hold;
        bit             do_inc;
        logic [IDW-1:0] hid;
        logic [WIDTH-1:0] hsoma;
        exp_t           e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            do_inc = 1'b0;
            if (rst) begin
                model_cnt = 0;
                hold      = 1'b0;
            end else begin
                check("ready_onehot", int'($onehot0(req_ready)), 1);
                check("ready_without_valid", int'(req_ready & ~req_valid), 0);
                if (resp_valid) check("grant_in_resp", int'(req_ready), 0);
                check("ops_count", int'(ops_count), model_cnt);
                if (hold) begin
                    check("hold_valid", int'(resp_valid), 1);
                    check("hold_id", int'(resp_id), int'(hid));
                    check("hold_soma", int'(resp_soma), int'(hsoma));
                end
                hold  = resp_valid && !resp_ready;
                hid   = resp_id;
                hsoma = resp_soma;
                if (resp_valid && resp_ready) begin
                    if (expq.size() == 0) begin
                        check("unexpected_resp", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        check("resp_id", int'(resp_id), int'(e.id));
                        check("resp_soma", int'(resp_soma), int'(e.soma));
                    end
                    do_inc = 1'b1;
                end
            end
            @(posedge clk);
            if (do_inc && !rst) model_cnt = (model_cnt + 1) % 256;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        do_reset();

        // all four requesters at once from reset: order 0,1,2,3
        for (int i = 0; i < NREQ; i++) add_op(i, i, 10);
        commit();
        wait_drain(200);

        // single requester
        add_op(1, 2, 3);
        commit();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 50);
        check("single_ready", int'(req_ready), 4'b0010);
        @(negedge clk);
        check("single_ready_drop", int'(req_ready), 0);
        wait_drain(100);
        check("single_ops_count", int'(ops_count), 5);

        // wrapping sums
        add_op(2, 15, 1);
        add_op(2, 9, 8);
        commit();
        wait_drain(100);

        // backpressure with a competing request arriving during RESP
        bp_mode = 1;
        @(negedge clk);
        add_op(3, 10, 5);
        commit();
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        add_op(0, 1, 1);
        commit();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", int'(resp_valid), 1);
            check("bp_soma", int'(resp_soma), 15);
            check("bp_id", int'(resp_id), 3);
            @(negedge clk);
        end
        bp_mode = 0;
        wait_drain(100);

        // reset while the operation is in CALC
        add_op(0, 6, 8);
        commit();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[0] && n < 50);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midcalc_resp_valid", int'(resp_valid), 0);
        check("midcalc_ops_count", int'(ops_count), 0);
        expq.delete();
        for (int i = 0; i < NREQ; i++) stimq[i].delete();
        model_ptr = 0;
        add_op(0, 6, 8);
        commit();
        repeat (2) @(negedge clk);
        check("midcalc_ready_in_rst", int'(req_ready), 0);
        check("midcalc_valid_in_rst", int'(resp_valid), 0);
        rst = 1'b0;
        wait_drain(100);
        check("midcalc_regrant_count", int'(ops_count), 1);

        // randomized batches under random backpressure
        bp_mode = 2;
        for (int bt = 0; bt < 4; bt++) begin
            for (int i = 0; i < NREQ; i++) begin
                n = int'($urandom_range(0, 3));
                for (int j = 0; j < n; j++)
                    add_op(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
            commit();
            wait_drain(600);
        end
        bp_mode = 0;

        // fairness between two persistent requesters, counter wrap
        do_reset();
        for (int j = 0; j < 150; j++) begin
            add_op(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            add_op(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
        commit();
        wait_drain(2000);
        check("fair_ops_count_wrap", int'(ops_count), 44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arbitro_somador.md
Name: arbitro_somador

Overview:
Round-robin arbiter and sequencer that time-shares one 4-bit `somador` adder between NREQ requesters. Each requester has its own valid/ready request channel. The block grants one requester, registers its operands, and drives them through the adder. It then returns the sum with the requester id on a single valid/ready response channel, and sits between the client units and the shared adder.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand/sum width; must match the somador instance.
- IDW, 2, id width (= clog2(NREQ)); set explicitly by the instantiator.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i has an operation pending.
- req_ready  out  NREQ  bit i: requester i is accepted this cycle (one-hot or zero).
- req_a  in  NREQ*WIDTH  operand a; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b, same packing as req_a.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  IDW  index of the requester that owns the result.
- resp_soma  out  WIDTH  sum (a+b) mod 2^WIDTH.
- ops_count  out  8  completed operations, wraps 255->0.

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, op_a/op_b/op_id=0, resp_valid=0, resp_id=0, resp_soma=0, req_ready=0, ops_count=0. An in-flight op is dropped with no response; requesters re-present their requests.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[grant]=1 combinationally, only in IDLE; all other bits are 0.
  - On the edge: op_a/op_b/op_id <= the granted requester's a, b, index; go to CALC.
  - No req_valid: stay in IDLE.
- CALC:
  - somador sees a=op_a, b=op_b.
  - On the edge: resp_soma<=soma, resp_id<=op_id, resp_valid<=1; go to RESP.
- RESP:
  - Outputs are held stable while resp_ready=0 (backpressure of any length).
  - On the edge with resp_ready=1: resp_valid<=0, ops_count<=ops_count+1, rr_ptr<=(op_id+1) mod NREQ; go to IDLE.
- Latency: accept edge to resp_valid=1 is 1 cycle.
- Throughput: at most 1 op per 3 cycles. There is no grant in RESP.
- Arithmetic: carry is discarded; the sum wraps mod 2^WIDTH (15+1=0, 8+8=0, 9+8=1).
- Fairness: a requester that has just been served has the lowest priority next round. No requester can starve while it holds req_valid.
- Requester rule: once req_valid[i]=1, the requester holds it and its operands stable until req_ready[i]=1. Operand changes before acceptance are sampled only on the accept edge.
- Simultaneous requests: exactly one grant per IDLE cycle. The others wait with req_ready=0.
- resp_ready=1 while resp_valid=0 has no effect.
- rr_ptr wrap: when NREQ-1 is served, the next scan starts at 0.

Decomposition:
- Shared package or header holds the FSM state encodings (IDLE=2'd0, CALC=2'd1, RESP=2'd2) and the ops_count width constant 8.
- Single sub-module: the existing `somador`, instantiated once as the shared datapath and fed from op_a/op_b.
- The round-robin pick is a function or always block inside arbitro_somador. It is not a separate module.

Test Plan:
- Reset mid-CALC: request a=6,b=8 from req0, assert rst during CALC. Required: resp_valid stays 0, ops_count=0, req0 is re-granted after rst deasserts.
- Single requester: req1 a=2,b=3, resp_ready=1. Required: req_ready=4'b0010 for one cycle; 1 cycle later resp_valid=1, resp_id=1, resp_soma=5; ops_count=1.
- Wrap: req2 a=15,b=1 then a=9,b=8. Required: resp_soma=0, then 1; resp_id=2 both times.
- Simultaneous requests: all four req_valid=1 from reset with a=i,b=10. Required: grant order 0,1,2,3; sums 10,11,12,13; each requester is granted exactly once.
- Backpressure: req3 a=10,b=5 with resp_ready=0 for 5 cycles. Required: resp_valid=1, resp_soma=15, resp_id=3 stable for all 5 cycles; no new grant until resp_ready=1.
- Fairness/counter: req0 and req1 held valid for 300 ops. Required: grants alternate 0,1,0,1...; ops_count wraps to 300-256=44.
